// File: rtl/zkn_aes_pkg.sv
// Shared constants and GF(2^8) helpers for the Zkn AES byte-substitution path.
// Inversion is x^254 via square-and-multiply, so inv(0) falls out as 0.
package zkn_aes_pkg;

  localparam logic [7:0] AES_POLY      = 8'h1B;
  localparam logic [7:0] AES_AFF_C     = 8'h63;
  localparam logic [7:0] AES_INV_AFF_C = 8'h05;

  typedef logic [7:0] aes_byte_t;

  function automatic aes_byte_t aff(input aes_byte_t a);
    return a
         ^ {a[3:0], a[7:4]}
         ^ {a[4:0], a[7:5]}
         ^ {a[5:0], a[7:6]}
         ^ {a[6:0], a[7]}
         ^ AES_AFF_C;
  endfunction

  function automatic aes_byte_t inv_aff(input aes_byte_t a);
    return {a[1:0], a[7:2]}
         ^ {a[4:0], a[7:5]}
         ^ {a[6:0], a[7]}
         ^ AES_INV_AFF_C;
  endfunction

  function automatic aes_byte_t gf_mul(input aes_byte_t a,
                                       input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? AES_POLY : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128
  function automatic aes_byte_t gf_inv(input aes_byte_t a);
    aes_byte_t sq;
    aes_byte_t r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int k = 0; k < 6; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/zkn_aes_sbox_if.sv
// Byte-in / substituted-bytes-out bundle between the Zkn
// decoder side (master) and the S-box unit (slave).
interface zkn_aes_sbox_if;
  import zkn_aes_pkg::*;

  logic      valid_i;
  logic      enc_dec_i;
  aes_byte_t x_i;
  logic      valid_o;
  aes_byte_t sx_o;
  aes_byte_t sx2_o;
  aes_byte_t sx4_o;
  aes_byte_t sx8_o;

  modport master (
    output valid_i, enc_dec_i, x_i,
    input  valid_o, sx_o, sx2_o, sx4_o, sx8_o
  );

  modport slave (
    input  valid_i, enc_dec_i, x_i,
    output valid_o, sx_o, sx2_o, sx4_o, sx8_o
  );

endinterface

// File: rtl/zkn_xtime.sv
// Multiply-by-x in GF(2^8) modulo 0x11B.
// Purely combinational; chained to build x2/x4/x8.
module zkn_xtime
  import zkn_aes_pkg::*;
(
  input  aes_byte_t a_i,
  output aes_byte_t y_o
);

  assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? AES_POLY : 8'h00);

endmodule

// File: rtl/zkn_aes_sbox.sv
// Registered forward/inverse AES S-box with x2/x4/x8 multiples.
// A single inverter is shared; direction muxes wrap it.
module zkn_aes_sbox
  import zkn_aes_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  zkn_aes_sbox_if.slave  bus
);

  aes_byte_t inv_in;
  aes_byte_t inv_out;
  aes_byte_t sx_d, sx2_d, sx4_d, sx8_d;
  aes_byte_t sx_q, sx2_q, sx4_q, sx8_q;
  logic      valid_q;

  assign inv_in  = bus.enc_dec_i ? bus.x_i : inv_aff(bus.x_i);
  assign inv_out = gf_inv(inv_in);
  assign sx_d    = bus.enc_dec_i ? aff(inv_out) : inv_out;

  zkn_xtime u_xt2 (.a_i(sx_d),  .y_o(sx2_d));
  zkn_xtime u_xt4 (.a_i(sx2_d), .y_o(sx4_d));
  zkn_xtime u_xt8 (.a_i(sx4_d), .y_o(sx8_d));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      sx_q    <= '0;
      sx2_q   <= '0;
      sx4_q   <= '0;
      sx8_q   <= '0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        sx_q  <= sx_d;
        sx2_q <= sx2_d;
        sx4_q <= sx4_d;
        sx8_q <= sx8_d;
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.sx_o    = sx_q;
  assign bus.sx2_o   = sx2_q;
  assign bus.sx4_o   = sx4_q;
  assign bus.sx8_o   = sx8_q;

endmodule

// File: tb/tb_zkn_aes_sbox.sv
// Directed bench for zkn_aes_sbox against a reference AES S-box table.
// Outputs are sampled 1 time unit after the rising edge.
module tb_zkn_aes_sbox;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] ISBOX [256];

  zkn_aes_sbox_if bus ();

  zkn_aes_sbox dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [7:0] x);
    bus.valid_i   = v;
    bus.enc_dec_i = e;
    bus.x_i       = x;
  endtask

  task automatic check_all(input string tag, input logic [7:0] s,
                           input logic [7:0] s2, input logic [7:0] s4,
                           input logic [7:0] s8);
    check({tag, ".sx"},  bus.sx_o,  s);
    check({tag, ".sx2"}, bus.sx2_o, s2);
    check({tag, ".sx4"}, bus.sx4_o, s4);
    check({tag, ".sx8"}, bus.sx8_o, s8);
  endtask

  task automatic check_model(input string tag, input logic [7:0] s);
    check_all(tag, s, xt(s), xt(xt(s)), xt(xt(xt(s))));
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] fwd;
    logic [7:0] e;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ISBOX[SBOX[i]] = 8'(i);

    rst_n = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    #2;
    check("rst.valid", {7'd0, bus.valid_o}, 8'h00);
    check_all("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 8'h00); step();
    check("fwd00.valid", {7'd0, bus.valid_o}, 8'h01);
    check_all("fwd00", 8'h63, 8'hc6, 8'h97, 8'h35);
    drive(1'b1, 1'b1, 8'h53); step(); check("fwd53", bus.sx_o, 8'hed);
    drive(1'b1, 1'b1, 8'h01); step(); check("fwd01", bus.sx_o, 8'h7c);
    drive(1'b1, 1'b1, 8'hff); step(); check("fwdff", bus.sx_o, 8'h16);

    drive(1'b1, 1'b0, 8'h63); step(); check("inv63", bus.sx_o, 8'h00);
    drive(1'b1, 1'b0, 8'hed); step(); check("inved", bus.sx_o, 8'h53);
    drive(1'b1, 1'b0, 8'h16); step(); check("inv16", bus.sx_o, 8'hff);
    drive(1'b1, 1'b0, 8'h00); step(); check("inv00", bus.sx_o, 8'h52);

    drive(1'b1, 1'b1, 8'hda); step();
    check_all("xtda", 8'h57, 8'hae, 8'h47, 8'h8e);
    drive(1'b1, 1'b1, 8'he6); step();
    check_all("xte6", 8'h8e, 8'h07, 8'h0e, 8'h1c);

    held = bus.sx_o;
    drive(1'b0, 1'b1, 8'h11); step();
    check("hold1.valid", {7'd0, bus.valid_o}, 8'h00);
    check("hold1.sx", bus.sx_o, held);
    drive(1'b0, 1'b0, 8'h9a); step();
    check("hold2.valid", {7'd0, bus.valid_o}, 8'h00);
    check("hold2.sx", bus.sx_o, held);
    check("hold2.sx2", bus.sx2_o, 8'h07);

    for (int i = 0; i < 256; i++) begin
      drive(1'b1, i[0], 8'(i)); step();
      e = i[0] ? SBOX[i] : ISBOX[i];
      check("strm.valid", {7'd0, bus.valid_o}, 8'h01);
      check_model($sformatf("strm%02h", i), e);
    end

    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 8'(i)); step();
      fwd = bus.sx_o;
      check($sformatf("rt%02h.fwd", i), fwd, SBOX[i]);
      drive(1'b1, 1'b0, fwd); step();
      check($sformatf("rt%02h.back", i), bus.sx_o, 8'(i));
    end

    drive(1'b1, 1'b1, 8'h53); step();
    check("pre_rst", bus.sx_o, 8'hed);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", {7'd0, bus.valid_o}, 8'h00);
    check_all("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'h53);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst.valid", {7'd0, bus.valid_o}, 8'h00);
    check_all("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check_all("post_rst2", 8'h00, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
